// File: rtl/render_pkg.sv
// Shared constants and state encoding for the rectangle renderer controller.
package render_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOR_W  = 3;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int W_W = 8;
  localparam int H_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rect_sweep.sv
// Raster column/row counters for one rectangle; load captures the extent,
// each enabled cycle advances one pixel and last flags the final pixel.
module rect_sweep
  import render_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           clear_i,
  input  logic           en_i,
  input  logic [W_W-1:0] w_i,
  input  logic [H_W-1:0] h_i,
  output logic [W_W-1:0] col_o,
  output logic [H_W-1:0] row_o,
  output logic           last_o
);

  localparam logic [W_W-1:0] COL_ONE = 1;
  localparam logic [H_W-1:0] ROW_ONE = 1;

  logic [W_W-1:0] col_q, col_d, wLim_q, wLim_d;
  logic [H_W-1:0] row_q, row_d, hLim_q, hLim_d;
  logic           colLast, rowLast;

  assign colLast = (col_q == wLim_q - COL_ONE);
  assign rowLast = (row_q == hLim_q - ROW_ONE);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    wLim_d = wLim_q;
    hLim_d = hLim_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      wLim_d = '0;
      hLim_d = '0;
    end else if (load_i) begin
      col_d  = '0;
      row_d  = '0;
      wLim_d = w_i;
      hLim_d = h_i;
    end else if (en_i) begin
      if (colLast) begin
        col_d = '0;
        row_d = rowLast ? '0 : row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      wLim_q <= '0;
      hLim_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      wLim_q <= wLim_d;
      hLim_q <= hLim_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = colLast && rowLast;

endmodule

// File: rtl/render_rect_ctrl.sv
// Round-robin command controller for the rectangle renderer: grants one of two
// requesters, then sweeps the rectangle one pixel per clock into the VGA plot port.
module render_rect_ctrl #(
  parameter int SCREEN_W = render_pkg::SCREEN_W,
  parameter int SCREEN_H = render_pkg::SCREEN_H,
  parameter int COLOR_W  = render_pkg::COLOR_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [15:0]          req_x,
  input  logic [13:0]          req_y,
  input  logic [15:0]          req_w,
  input  logic [13:0]          req_h,
  input  logic [2*COLOR_W-1:0] req_color,
  input  logic                 abort,
  output logic [7:0]           r_x,
  output logic [6:0]           r_y,
  output logic [COLOR_W-1:0]   color,
  output logic                 writeEn,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id
);

  import render_pkg::*;

  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);

  state_e               state_q, state_d;
  logic                 lastGrant_q, lastGrant_d;
  logic [X_W-1:0]       x0_q, x0_d;
  logic [Y_W-1:0]       y0_q, y0_d;
  logic [COLOR_W-1:0]   cmdColor_q, cmdColor_d;
  logic                 id_q, id_d;
  logic [7:0]           rX_q, rX_d;
  logic [6:0]           rY_q, rY_d;
  logic [COLOR_W-1:0]   colorOut_q, colorOut_d;
  logic                 writeEn_q, writeEn_d;
  logic                 done_q, done_d;
  logic                 doneId_q, doneId_d;

  logic                 grant, accept;
  logic [X_W-1:0]       selX;
  logic [Y_W-1:0]       selY;
  logic [W_W-1:0]       selW;
  logic [H_W-1:0]       selH;
  logic [COLOR_W-1:0]   selColor;
  logic                 sweepLoad, sweepClear, sweepEn, sweepLast;
  logic [W_W-1:0]       col;
  logic [H_W-1:0]       row;
  logic [8:0]           px;
  logic [7:0]           py;

  // Contention goes to whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~lastGrant_q;
      default: grant = 1'b0;
    endcase
  end

  assign req_ready = (resetn && state_q == IDLE) ?
                     ((grant ? 2'b10 : 2'b01) & req_valid) : 2'b00;
  assign accept    = |req_ready;

  assign selX     = grant ? req_x[15:8] : req_x[7:0];
  assign selY     = grant ? req_y[13:7] : req_y[6:0];
  assign selW     = grant ? req_w[15:8] : req_w[7:0];
  assign selH     = grant ? req_h[13:7] : req_h[6:0];
  assign selColor = grant ? req_color[2*COLOR_W-1:COLOR_W] : req_color[COLOR_W-1:0];

  assign px = {1'b0, x0_q} + {1'b0, col};
  assign py = {1'b0, y0_q} + {1'b0, row};

  rect_sweep uSweep (
    .clk     (clk),
    .rst_n   (resetn),
    .load_i  (sweepLoad),
    .clear_i (sweepClear),
    .en_i    (sweepEn),
    .w_i     (selW),
    .h_i     (selH),
    .col_o   (col),
    .row_o   (row),
    .last_o  (sweepLast)
  );

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    cmdColor_d  = cmdColor_q;
    id_d        = id_q;
    rX_d        = rX_q;
    rY_d        = rY_q;
    colorOut_d  = colorOut_q;
    writeEn_d   = 1'b0;
    done_d      = 1'b0;
    doneId_d    = doneId_q;
    sweepLoad   = 1'b0;
    sweepClear  = 1'b0;
    sweepEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lastGrant_d = grant;
          x0_d        = selX;
          y0_d        = selY;
          cmdColor_d  = selColor;
          id_d        = grant;
          if (selW == '0 || selH == '0) begin
            state_d = DONE;
          end else begin
            state_d   = DRAW;
            sweepLoad = 1'b1;
          end
        end
      end
      DRAW: begin
        // Off-screen pixels still take their cycle; only the strobe is masked.
        sweepEn    = 1'b1;
        rX_d       = px[7:0];
        rY_d       = py[6:0];
        colorOut_d = cmdColor_q;
        writeEn_d  = (px < SCREEN_W9) && (py < SCREEN_H8);
        if (sweepLast || abort) state_d = DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        doneId_d   = id_q;
        sweepClear = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      x0_q        <= '0;
      y0_q        <= '0;
      cmdColor_q  <= '0;
      id_q        <= 1'b0;
      rX_q        <= '0;
      rY_q        <= '0;
      colorOut_q  <= '0;
      writeEn_q   <= 1'b0;
      done_q      <= 1'b0;
      doneId_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      cmdColor_q  <= cmdColor_d;
      id_q        <= id_d;
      rX_q        <= rX_d;
      rY_q        <= rY_d;
      colorOut_q  <= colorOut_d;
      writeEn_q   <= writeEn_d;
      done_q      <= done_d;
      doneId_q    <= doneId_d;
    end
  end

  assign r_x     = rX_q;
  assign r_y     = rY_q;
  assign color   = colorOut_q;
  assign writeEn = writeEn_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = doneId_q;

endmodule

// File: doc/render_rect_ctrl.md
# render_rect_ctrl

Command-level controller for the rectangle renderer. Two requesters, such as the game logic and the UI overlay, submit filled-rectangle commands over valid/ready handshakes. The block grants one requester round-robin, latches the command, and sweeps every pixel of the rectangle in raster order, one pixel per clock. It drives the VGA adapter's plot coordinate, colour and `writeEn` directly, clipping pixels that fall off the 160x120 screen.

## Interface
Parameters:
- `SCREEN_W`, 160, visible width in pixels
- `SCREEN_H`, 120, visible height in pixels
- `COLOR_W`, 3, colour width

Ports:
- `clk`  in  1  system clock
- `resetn`  in  1  reset; one clock; reset is asynchronous and active-low
- `req_valid`  in  2  per-requester command valid; bit i belongs to requester i
- `req_ready`  out  2  per-requester accept, one-hot or zero; combinational
- `req_x`  in  16  two 8-bit origin X values; requester i uses bits [8i+7:8i]
- `req_y`  in  14  two 7-bit origin Y values
- `req_w`  in  16  two 8-bit widths, range 0..255
- `req_h`  in  14  two 7-bit heights, range 0..127
- `req_color`  in  2*COLOR_W  colours
- `abort`  in  1  synchronous request to terminate the current sweep
- `r_x`  out  8  plot X, registered
- `r_y`  out  7  plot Y, registered
- `color`  out  COLOR_W  plot colour, registered
- `writeEn`  out  1  plot strobe to VGA, registered
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when a command completes or is aborted
- `done_id`  out  1  requester index of the completed command

## Operation
- FSM states: IDLE, DRAW, DONE.
- Reset: state IDLE, `last_grant`=1 (so requester 0 wins first), counters 0. All outputs are 0.
- IDLE arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to `~last_grant`.
  - `req_ready[g]` is high only in IDLE, for the granted requester g.
  - On acceptance, latch x0, y0, w, h, colour and id, and set `last_grant`=g.
- Zero-size command (w==0 or h==0): go directly to DONE with no `writeEn`.
- Otherwise go to DRAW with col=0 and row=0.
- DRAW, each cycle:
  - px = x0+col, 9-bit; py = y0+row, 8-bit.
  - Register `r_x`=px[7:0], `r_y`=py[6:0] and `color`.
  - `writeEn` = (px < SCREEN_W) && (py < SCREEN_H).
  - Clipped pixels still consume their cycle.
  - Raster order: col increments; at col==w-1, col wraps to 0 and row increments.
  - The cycle with col==w-1 and row==h-1 is the last pixel; then go to DONE.
- `abort` sampled high in DRAW: the current cycle's pixel is still emitted, then go to DONE. `abort` has no effect in IDLE or DONE.
- DONE: lasts exactly 1 cycle. `done`=1, `done_id`=latched id, `writeEn`=0, then return to IDLE.
- Requesters must hold valid and fields stable until ready. A deasserted valid before ready is legal and withdraws the request.
- Asynchronous reset during DRAW: the sweep is dropped, no `done` pulse, and all outputs go to 0 immediately.

## Timing
- Handshake completes in cycle T (valid && ready).
- DRAW occupies T+1 .. T+w*h.
- The pixel for DRAW cycle k is visible on the outputs in cycle k+1. The first `writeEn` appears in T+2 and the last in T+1+w*h.
- DONE occupies cycle T+1+w*h, overlapping the last pixel output. `done` is registered and seen in T+2+w*h.
- The next command can be accepted in T+2+w*h.
- Zero-size command: DONE at T+1, `done` seen at T+2.
- Throughput: 1 pixel/clock. Per-command overhead is 2 cycles.

## Structure
- The shared package `render_pkg` holds:
  - `SCREEN_W`, `SCREEN_H`, `COLOR_W`
  - the state encoding (IDLE=2'd0, DRAW=2'd1, DONE=2'd2)
  - the `rect_cmd` field widths
- One sub-module, `rect_sweep`, holds the col/row counters with load, enable, `last` flag and synchronous clear. Arbiter, FSM and output registers stay in the top.

## Test plan
- Req0 only: x=10, y=20, w=3, h=2, colour=5 -> six `writeEn` pulses, in order (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), colour 5 each. `done` one cycle after the last pulse, `done_id`=0.
- Both valid after reset -> req0 granted first, then req1. With both continuously valid, grants alternate 0,1,0,1.
- Clip: x=158, y=119, w=4, h=2 -> 8 DRAW cycles. `writeEn` is high only for (158,119) and (159,119).
- w=0, h=5 -> no `writeEn`, `done` at T+2, `busy` high for exactly 1 cycle.
- `abort` asserted in the 3rd DRAW cycle of a 4x4 command -> exactly 3 pixels written, then `done`. Next request accepted 1 cycle later.
- `resetn` low mid-sweep (w=8, h=8) -> all outputs 0 in the same cycle. No `done`. After release the FSM is in IDLE and requester 0 has priority.
